// File: rtl/uart_word_tx.sv
// 32-bit word UART transmitter: four back-to-back 8N1 frames, LSB byte first.
// Define UART_WORD_TX_PARITY_EN to insert an even-parity bit before each stop bit.
`timescale 1ns/1ps
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [1:0]        byte_idx, byte_nxt;
  logic [31:0]       shreg, shreg_nxt;
  logic [7:0]        cur_byte;
  logic              baud_wrap;
  logic              tx_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      byte_idx <= byte_nxt;
      shreg    <= shreg_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // The last stop bit is cut one cycle short and the DONE state fills that
  // cycle, so the registered done pulse lands exactly when the word ends and
  // the state is already IDLE for an immediate next accept.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_idx;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;
    baud_wrap = (baud_cnt == BAUD_LAST);

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = START;
          shreg_nxt = data_in;
          byte_nxt  = '0;
          bit_nxt   = '0;
          baud_nxt  = '0;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_nxt = DATA;
          baud_nxt  = '0;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
            bit_nxt = '0;
`ifdef UART_WORD_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      PARITY: begin
        if (baud_wrap) begin
          state_nxt = STOP;
          baud_nxt  = '0;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if ((byte_idx == 2'd3) && (baud_cnt == STOP_LAST)) begin
          state_nxt = DONE;
          baud_nxt  = '0;
          byte_nxt  = '0;
        end else if (baud_wrap) begin
          state_nxt = START;
          baud_nxt  = '0;
          byte_nxt  = byte_idx + 2'd1;
          shreg_nxt = {8'h00, shreg[31:8]};
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from the next-state view of the line.
    cur_byte = shreg_nxt[7:0];
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = cur_byte[bit_nxt];
      PARITY:  tx_nxt = ^cur_byte;
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: per-cycle behavioural model plus
// literal decode/timing checks. Honours UART_WORD_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_word_tx;

  localparam int C = 4;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int WORD = 4 * FRAME * C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] data_in;
  logic        tx, busy, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dcount = 0;
  bit checking = 1'b0;
  bit capturing = 1'b0;
  logic trace [0:1023];
  int tcnt = 0;

  bit          mact;
  int          mk;
  logic [31:0] mword;
  logic        etx, ebusy, edone;

  uart_word_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .data_in(data_in),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level k cycles after the accept edge, from frame arithmetic.
  function automatic logic modelTx(int k, logic [31:0] w);
    int   byte_n, b;
    logic [7:0] by;
    byte_n = k / (FRAME * C);
    b = (k % (FRAME * C)) / C;
    by = 8'(w >> (8 * byte_n));
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
`ifdef UART_WORD_TX_PARITY_EN
    if (b == 9) return ^by;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mact <= 1'b0; mk <= 0; etx <= 1'b1; ebusy <= 1'b0; edone <= 1'b0;
    end else if (mact) begin
      if (mk + 1 == WORD) begin
        mact <= 1'b0; etx <= 1'b1; ebusy <= 1'b0; edone <= 1'b1;
      end else begin
        mk <= mk + 1; etx <= modelTx(mk + 1, mword); ebusy <= 1'b1; edone <= 1'b0;
      end
    end else if (start) begin
      mact <= 1'b1; mk <= 0; mword <= data_in;
      etx <= modelTx(0, data_in); ebusy <= 1'b1; edone <= 1'b0;
    end else begin
      etx <= 1'b1; ebusy <= 1'b0; edone <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model_tx", tx, etx);
      checkOutput("model_busy", busy, ebusy);
      checkOutput("model_done", done, edone);
      if (done === 1'b1) dcount++;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (capturing && tcnt < 1024) begin
      trace[tcnt] = tx;
      tcnt++;
    end
  endtask

  // Raise start for one edge; trace[0] becomes the first start-bit cycle.
  task automatic applyStimulus(input logic [31:0] w, output int acc);
    data_in = w;
    start = 1'b1;
    tcnt = 0;
    capturing = 1'b1;
    tick();
    acc = cyc;
    start = 1'b0;
  endtask

  task automatic waitDone(output int at);
    bit seen = 1'b0;
    at = -1;
    for (int i = 0; i < 3 * WORD && !seen; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [7:0] decodeByte(int base, int idx);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = trace[base + idx * FRAME * C + (1 + i) * C + C / 2];
    return r;
  endfunction

  task automatic checkWord(input string name, input int base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      checkOutput({name, "_byte"}, decodeByte(base, i), 8'(w >> (8 * i)));
      checkOutput({name, "_startbit"}, trace[base + i * FRAME * C + C / 2], 1'b0);
      checkOutput({name, "_stopbit"}, trace[base + i * FRAME * C + (FRAME - 1) * C + C / 2], 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a, d, d1, d2, dc0;
    logic [31:0] w;
    rst_n = 1'b0; start = 1'b0; data_in = '0;

    repeat (3) tick();
    checking = 1'b1;
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("idle_tx", tx, 1'b1);
    end

    $display("[TB] single word");
    applyStimulus(32'h12345678, a);
    checkOutput("accept_busy", busy, 1'b1);
    checkOutput("accept_tx", tx, 1'b0);
    waitDone(d);
    checkOutput("done_latency", d - a, WORD);
    checkOutput("done_busy", busy, 1'b0);
    checkOutput("byte0", decodeByte(0, 0), 8'h78);
    checkOutput("byte1", decodeByte(0, 1), 8'h56);
    checkOutput("byte2", decodeByte(0, 2), 8'h34);
    checkOutput("byte3", decodeByte(0, 3), 8'h12);
    checkOutput("bit3_byte0", trace[4 * C + 1], 1'b1);
    checkOutput("bit7_byte0", trace[8 * C + 1], 1'b0);
    repeat (5) tick();

    $display("[TB] ignored start");
    dc0 = dcount;
    applyStimulus(32'hA5A5A5A5, a);
    repeat (49) tick();
    data_in = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(d);
    checkWord("ignored", 0, 32'hA5A5A5A5);
    repeat (WORD + 10) tick();
    checkOutput("ignored_done_count", dcount - dc0, 1);

    $display("[TB] back to back");
    data_in = 32'h00000000; start = 1'b1;
    tcnt = 0; capturing = 1'b1;
    tick();
    data_in = 32'hFFFFFFFF;
    waitDone(d1);
    tick();
    start = 1'b0;
    waitDone(d2);
    checkOutput("b2b_gap", d2 - d1, WORD + 1);
    checkWord("b2b_first", 0, 32'h00000000);
    checkWord("b2b_second", WORD + 1, 32'hFFFFFFFF);
    repeat (5) tick();

    $display("[TB] mid-word reset");
    dc0 = dcount;
    applyStimulus($urandom, a);
    repeat (69) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midreset_tx", tx, 1'b1);
    checkOutput("midreset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (WORD) tick();
    checkOutput("midreset_no_done", dcount - dc0, 0);
    w = $urandom;
    applyStimulus(w, a);
    waitDone(d);
    checkOutput("post_reset_latency", d - a, WORD);
    checkWord("post_reset", 0, w);

    $display("[TB] randomized words");
    for (int n = 0; n < 6; n++) begin
      bit seen;
      w = $urandom;
      applyStimulus(w, a);
      seen = 1'b0;
      for (int i = 0; i < 2 * WORD && !seen; i++) begin
        start = ($urandom_range(0, 7) == 0);
        data_in = $urandom;
        tick();
        if (done === 1'b1) seen = 1'b1;
      end
      start = 1'b0;
      if (!seen) checkOutput("random_done_timeout", 32'd0, 32'd1);
      checkWord("random", 0, w);
      repeat ($urandom_range(0, 5)) tick();
    end

`ifdef UART_WORD_TX_PARITY_EN
    $display("[TB] parity");
    applyStimulus(32'h00000701, a);
    waitDone(d);
    checkOutput("parity_latency", d - a, 176);
    checkOutput("parity0", trace[0 * FRAME * C + 9 * C + 1], 1'b1);
    checkOutput("parity1", trace[1 * FRAME * C + 9 * C + 1], 1'b1);
    checkOutput("parity2", trace[2 * FRAME * C + 9 * C + 1], 1'b0);
    checkOutput("parity3", trace[3 * FRAME * C + 9 * C + 1], 1'b0);
`endif

    capturing = 1'b0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
